// File: rtl/gate_activation.sv
// gate_activation: two-stage streaming hard-sigmoid / hard-tanh stage that sits
// after the multiply-add unit, with valid/ready on both sides and a per-vector
// out_last marker.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_data/in_func      signed Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH value and
//                        function select (0 = hard-sigmoid, 1 = hard-tanh)
//   in_valid/in_ready    input handshake
//   out_data/out_valid   activated value and its valid
//   out_ready            downstream accept
//   out_last             marks the VEC_LEN-th output of each gate vector
//   sat_cnt              saturating count of clamped outputs
//
// Optional feature: define ACT_SAT_COUNT_EN to build the clamp counter;
// otherwise sat_cnt is tied to zero.
module gate_activation #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FRACT_WIDTH = 8,
    parameter int unsigned VEC_LEN     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_func,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [15:0]           sat_cnt
);

    localparam int unsigned CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int          ONE_I  = 1 << FRACT_WIDTH;
    localparam int          HALF_I = (FRACT_WIDTH > 0) ? (1 << (FRACT_WIDTH - 1)) : 0;

    localparam logic signed [DATA_WIDTH:0] ONE  = (DATA_WIDTH+1)'(ONE_I);
    localparam logic signed [DATA_WIDTH:0] HALF = (DATA_WIDTH+1)'(HALF_I);
    localparam logic [CNT_W-1:0]           LAST = CNT_W'(VEC_LEN - 1);

    logic                         s1_valid;
    logic                         s1_func;
    logic signed [DATA_WIDTH:0]   s1_val;
    logic signed [DATA_WIDTH:0]   in_ext;
    logic signed [DATA_WIDTH:0]   s1_next;
    logic signed [DATA_WIDTH:0]   lo;
    logic [DATA_WIDTH-1:0]        s2_next;
    logic [CNT_W-1:0]             cnt;
    logic                         s1_load;
    logic                         s2_load;
    logic                         out_fire;

    // Pipeline advance conditions; a stage loads when empty or draining.
    assign s2_load  = !s2_busy();
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign out_fire = out_valid && out_ready;
    assign out_last = out_valid && (cnt == LAST);

    function automatic logic s2_busy();
        return out_valid && !out_ready;
    endfunction

    // Stage 1: hard-sigmoid pre-scale (floor(x/4) + 0.5) or pass-through for tanh.
    always_comb begin
        in_ext = {in_data[DATA_WIDTH-1], in_data};
        if (in_func) begin
            s1_next = in_ext;
        end else begin
            s1_next = (in_ext >>> 2) + HALF;
        end
    end

    // Stage 2: clamp to [0, ONE] (sigmoid) or [-ONE, ONE] (tanh); result fits DATA_WIDTH.
    always_comb begin
        if (s1_func) begin
            lo = -ONE;
        end else begin
            lo = '0;
        end
        if (s1_val > ONE) begin
            s2_next = DATA_WIDTH'(ONE);
        end else if (s1_val < lo) begin
            s2_next = DATA_WIDTH'(lo);
        end else begin
            s2_next = DATA_WIDTH'(s1_val);
        end
    end

    // Pipeline registers and output-transfer vector counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_func   <= 1'b0;
            s1_val    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            cnt       <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_val  <= s1_next;
                    s1_func <= in_func;
                end
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= s2_next;
                end
            end
            if (out_fire) begin
                cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

`ifdef ACT_SAT_COUNT_EN
    logic s2_clamp;
    logic sat_flag;

    // Boundary values are in range, so only strict overshoot counts as clamped.
    assign s2_clamp = (s1_val > ONE) || (s1_val < lo);

    // Clamp flag travels with out_data; counter saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
            sat_cnt  <= 16'h0000;
        end else begin
            if (s2_load && s1_valid) begin
                sat_flag <= s2_clamp;
            end
            if (out_fire && sat_flag && (sat_cnt != 16'hFFFF)) begin
                sat_cnt <= sat_cnt + 16'd1;
            end
        end
    end
`else
    assign sat_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_gate_activation.sv
// Randomized and directed bench for gate_activation against a behavioural model.
module tb_gate_activation;

    localparam int DW   = 16;
    localparam int FW   = 8;
    localparam int VL   = 16;
    localparam int ONE  = 1 << FW;
    localparam int HALF = 1 << (FW - 1);
`ifdef ACT_SAT_COUNT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] d;
        bit            f;
        bit            has_exp;
        logic [DW-1:0] e;
    } src_t;

    typedef struct {
        logic [DW-1:0] d;
        bit            cl;
        int            t;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_func = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic [15:0]   sat_cnt;

    src_t src_q[$];
    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   n_acc = 0;
    int   n_last = 0;
    int   exp_sat = 0;
    bit   chk_lat = 1'b0;

    gate_activation #(.DATA_WIDTH(DW), .FRACT_WIDTH(FW), .VEC_LEN(VL)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_func(in_func), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Spec-level model: floor(x/4)+HALF or x, then clamp.
    function automatic logic [DW-1:0] ref_act(input logic [DW-1:0] din, input bit f, output bit cl);
        int x, t, lo;
        logic [31:0] tv;
        x = $signed(din);
        if (f) t = x;
        else t = ((x >= 0) ? x / 4 : -((-x + 3) / 4)) + HALF;
        lo = f ? -ONE : 0;
        cl = 1'b0;
        if (t > ONE) begin t = ONE; cl = 1'b1; end
        else if (t < lo) begin t = lo; cl = 1'b1; end
        tv = t;
        return tv[DW-1:0];
    endfunction

    task automatic push(input logic [DW-1:0] d, input bit f, input bit has_exp, input logic [DW-1:0] e);
        src_t s;
        s.d = d; s.f = f; s.has_exp = has_exp; s.e = e;
        src_q.push_back(s);
    endtask

    // One clock: drive at negedge, sample settled handshake before the rising edge.
    task automatic cycle(input bit ordy, input bit ien);
        exp_t e;
        src_t s;
        bit   cl;
        @(negedge clk);
        out_ready = ordy;
        if (ien && src_q.size() > 0) begin
            in_valid = 1'b1; in_data = src_q[0].d; in_func = src_q[0].f;
        end else begin
            in_valid = 1'b0; in_data = DW'($urandom); in_func = 1'($urandom);
        end
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e.d));
                check("out_last", 32'(out_last), 32'((n_out % VL) == VL - 1));
                check("sat_cnt", 32'(sat_cnt), 32'(exp_sat));
                if (chk_lat) check("latency", 32'(cyc - e.t), 32'd2);
                if (out_last) n_last++;
                n_out++;
                if (SAT_EN && e.cl && exp_sat < 65535) exp_sat++;
            end
        end
        if (in_valid && in_ready) begin
            s = src_q.pop_front();
            e.d = ref_act(s.d, s.f, cl);
            if (s.has_exp) e.d = s.e;
            e.cl = cl;
            e.t = cyc;
            exp_q.push_back(e);
            n_acc++;
        end
        cyc++;
    endtask

    task automatic drain(input int mode, input int bound);
        int k;
        k = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && k < bound) begin
            cycle((mode == 0) ? 1'b1 : ((mode == 1) ? 1'(cyc) : 1'($urandom)), 1'b1);
            k++;
        end
        if (src_q.size() > 0 || exp_q.size() > 0)
            check("drain_timeout", 32'(src_q.size() + exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        src_q.delete(); exp_q.delete();
        n_out = 0; n_acc = 0; n_last = 0; exp_sat = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] sig_in [6]  = '{16'h0000, 16'h0200, 16'h0400, 16'hFC00, 16'h0001, 16'hFFFF};
        logic [DW-1:0] sig_out[6]  = '{16'h0080, 16'h0100, 16'h0100, 16'h0000, 16'h0080, 16'h007F};
        logic [DW-1:0] tanh_in [5] = '{16'h0080, 16'h0100, 16'h0300, 16'h8000, 16'hFF00};
        logic [DW-1:0] tanh_out[5] = '{16'h0080, 16'h0100, 16'h0100, 16'hFF00, 16'hFF00};
        int k;

        // Reset state
        do_reset();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed sigmoid with latency check
        chk_lat = 1'b1;
        for (int i = 0; i < 6; i++) push(sig_in[i], 1'b0, 1'b1, sig_out[i]);
        drain(0, 100);
        chk_lat = 1'b0;

        // Directed tanh
        do_reset();
        for (int i = 0; i < 5; i++) push(tanh_in[i], 1'b1, 1'b1, tanh_out[i]);
        drain(0, 100);
        check("tanh_sat_cnt", 32'(sat_cnt), SAT_EN ? 32'd2 : 32'd0);

        // Backpressure: only two elements buffer, head output holds
        do_reset();
        for (int i = 1; i <= 4; i++) push(DW'(i), 1'b1, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1);
            if (i >= 2) check("bp_hold_data", 32'(out_data), 32'd1);
        end
        check("bp_accepted", 32'(n_acc), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        drain(0, 100);
        check("bp_out_count", 32'(n_out), 32'd4);

        // Framing, ready high then toggling
        do_reset();
        chk_lat = 1'b1;
        for (int i = 0; i < 32; i++) push(DW'($urandom), 1'($urandom), 1'b0, '0);
        drain(0, 200);
        chk_lat = 1'b0;
        check("frame_lasts", 32'(n_last), 32'd2);
        do_reset();
        for (int i = 0; i < 32; i++) push(DW'($urandom), 1'($urandom), 1'b0, '0);
        drain(1, 400);
        check("frame_toggle_lasts", 32'(n_last), 32'd2);

        // Asynchronous reset mid-vector with the pipe full
        do_reset();
        for (int i = 0; i < 20; i++) push(16'h7FFF, 1'b1, 1'b0, '0);
        k = 0;
        while (n_out < 5 && k < 100) begin cycle(1'b1, 1'b1); k++; end
        check("mid_reached", 32'(n_out), 32'd5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_out_last", 32'(out_last), 32'd0);
        check("mid_sat_cnt", 32'(sat_cnt), 32'd0);
        do_reset();
        for (int i = 0; i < 16; i++) push(DW'($urandom), 1'($urandom), 1'b0, '0);
        drain(0, 200);
        check("mid_lasts", 32'(n_last), 32'd1);

        // Randomized traffic and backpressure
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (src_q.size() < 2) push(DW'($urandom), 1'($urandom), 1'b0, '0);
            cycle(1'($urandom), 1'($urandom));
        end
        drain(2, 400);
        check("rand_sat_cnt", 32'(sat_cnt), 32'(exp_sat));

`ifdef ACT_SAT_COUNT_EN
        // Saturating counter: more clamped outputs than the counter can hold
        do_reset();
        for (int i = 0; i < 65537; i++) push(16'h7FFF, 1'b1, 1'b0, '0);
        drain(0, 66000);
        check("sat_max", 32'(sat_cnt), 32'h0000FFFF);
        for (int i = 0; i < 2; i++) push(16'h8000, 1'b1, 1'b0, '0);
        drain(0, 100);
        check("sat_hold", 32'(sat_cnt), 32'h0000FFFF);
`else
        check("no_sat_cnt", 32'(sat_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
